// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared constants and helpers for the buffered AXI4-Stream master
package axis_pkg;

    localparam int PKT_CUT_THROUGH = 0;
    localparam int PKT_STORE_FWD   = 1;

    localparam int AXIS_TDATA_WIDTH_DEFAULT = 32;
    localparam int AXIS_TKEEP_WIDTH_DEFAULT = AXIS_TDATA_WIDTH_DEFAULT / 8;

    // Ceiling log2 clamped to 1 so a single-entry ring still gets a real pointer bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axis_master_buf_if.sv
// rtl/axis_master_buf_if.sv - upstream fifo handshake plus downstream AXI4-Stream master signals
interface axis_master_buf_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    import axis_pkg::*;

    localparam int KW = keep_width(AXIS_TDATA_WIDTH);

    logic                        fifo_tready;
    logic                        fifo_tvalid;
    logic                        fifo_tlast;
    logic [KW-1:0]               fifo_tkeep;
    logic [AXIS_TDATA_WIDTH-1:0] fifo_tdata;

    logic                        tready;
    logic                        tvalid;
    logic                        tlast;
    logic [KW-1:0]               tkeep;
    logic [KW-1:0]               tstrb;
    logic [AXIS_TDATA_WIDTH-1:0] tdata;

    modport master (
        output fifo_tready,
        input  fifo_tvalid, fifo_tlast, fifo_tkeep, fifo_tdata,
        input  tready,
        output tvalid, tlast, tkeep, tstrb, tdata
    );

    modport slave (
        input  fifo_tready,
        output fifo_tvalid, fifo_tlast, fifo_tkeep, fifo_tdata,
        output tready,
        input  tvalid, tlast, tkeep, tstrb, tdata
    );

endinterface

// File: rtl/axis_buf_ring.sv
// rtl/axis_buf_ring.sv - DEPTH-1 entry ring holding {tlast, tkeep, tdata} behind the output register
module axis_buf_ring
    import axis_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37,
    localparam int PW   = clog2(DEPTH - 1),
    localparam int CW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-2];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Entry count is DEPTH-1, not a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 2)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_rd_en) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(i_wr_en) - CW'(i_rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH - 1));

endmodule

// File: rtl/axis_master_buf.sv
// rtl/axis_master_buf.sv - DEPTH-word buffered AXI4-Stream master with optional store-and-forward
module axis_master_buf
    import axis_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int DEPTH            = 4,
    parameter int PKT_MODE         = PKT_CUT_THROUGH,
    parameter int AFULL_THRESH     = DEPTH - 1,
    localparam int KW              = keep_width(AXIS_TDATA_WIDTH),
    localparam int LW              = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    axis_master_buf_if.master     bus,
    output logic [LW-1:0]         level,
    output logic                  afull
);

    localparam int RW = AXIS_TDATA_WIDTH + KW + 1;

    logic                        r_valid;
    logic                        r_last;
    logic [KW-1:0]               r_keep;
    logic [AXIS_TDATA_WIDTH-1:0] r_data;
    logic [LW-1:0]               r_level;
    logic [LW-1:0]               r_pkt_cnt;
    logic                        r_fifo_tready;
    logic                        r_afull;
    logic                        r_stream;

    logic          w_in_xfer;
    logic          w_out_xfer;
    logic          w_out_free;
    logic          w_elig;
    logic          w_load_ring;
    logic          w_load_in;
    logic          w_load;
    logic          w_ring_wr;
    logic          w_ring_empty;
    logic          w_ring_full;
    logic [LW-1:0] w_level_nxt;
    logic [LW-1:0] w_pkt_nxt;
    logic [RW-1:0] w_in_word;
    logic [RW-1:0] w_ring_rdata;
    logic [RW-1:0] w_load_word;

    assign w_in_xfer   = bus.fifo_tvalid & r_fifo_tready;
    assign w_out_xfer  = r_valid & bus.tready;
    assign w_out_free  = ~r_valid | w_out_xfer;
    assign w_in_word   = {bus.fifo_tlast, bus.fifo_tkeep, bus.fifo_tdata};
    assign w_level_nxt = r_level + LW'(w_in_xfer) - LW'(w_out_xfer);
    assign w_pkt_nxt   = r_pkt_cnt + LW'(w_in_xfer & bus.fifo_tlast) - LW'(w_out_xfer & r_last);

    // Store-and-forward releases a word once a whole packet is inside, the buffer is
    // full (long packets would otherwise deadlock), or its packet is already streaming.
    assign w_elig = (PKT_MODE == PKT_CUT_THROUGH) || r_stream ||
                    (w_pkt_nxt != '0) || (w_level_nxt == LW'(DEPTH));

    assign w_load_ring = w_out_free & ~w_ring_empty & w_elig;
    assign w_load_in   = w_out_free & w_ring_empty & w_in_xfer & w_elig;
    assign w_load      = w_load_ring | w_load_in;
    assign w_ring_wr   = w_in_xfer & ~w_load_in;
    assign w_load_word = w_load_ring ? w_ring_rdata : w_in_word;

    axis_buf_ring #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_ring_wr),
        .i_wr_data (w_in_word),
        .i_rd_en   (w_load_ring),
        .o_rd_data (w_ring_rdata),
        .o_empty   (w_ring_empty),
        .o_full    (w_ring_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_keep        <= '0;
            r_data        <= '0;
            r_level       <= '0;
            r_pkt_cnt     <= '0;
            r_fifo_tready <= 1'b0;
            r_afull       <= 1'b0;
            r_stream      <= 1'b0;
        end else begin
            assert (!(w_ring_wr && w_ring_full && !w_load_ring));
            r_level       <= w_level_nxt;
            r_fifo_tready <= (w_level_nxt < LW'(DEPTH));
            r_afull       <= (w_level_nxt >= LW'(AFULL_THRESH));
            r_pkt_cnt     <= (PKT_MODE == PKT_STORE_FWD) ? w_pkt_nxt : '0;
            if (w_load) begin
                r_valid                  <= 1'b1;
                {r_last, r_keep, r_data} <= w_load_word;
                r_stream                 <= ~w_load_word[RW-1];
            end else if (w_out_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.fifo_tready = r_fifo_tready;
    assign bus.tvalid      = r_valid;
    assign bus.tlast       = r_last;
    assign bus.tkeep       = r_keep;
    assign bus.tstrb       = '1;
    assign bus.tdata       = r_data;
    assign level           = r_level;
    assign afull           = r_afull;

endmodule

// File: tb/tb_axis_master_buf.sv
// tb/tb_axis_master_buf.sv - self-checking bench for axis_master_buf in cut-through and store-and-forward modes
module tb_axis_master_buf;
    import axis_pkg::*;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axis_master_buf_if #(.AXIS_TDATA_WIDTH(DW)) bus_a ();
    axis_master_buf_if #(.AXIS_TDATA_WIDTH(DW)) bus_b ();

    logic [2:0] level_a, level_b;
    logic       afull_a, afull_b;

    axis_master_buf #(
        .AXIS_TDATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(PKT_CUT_THROUGH), .AFULL_THRESH(3)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .level(level_a), .afull(afull_a)
    );

    axis_master_buf #(
        .AXIS_TDATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(PKT_STORE_FWD), .AFULL_THRESH(3)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .level(level_b), .afull(afull_b)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic [KW-1:0] k;
        logic          rdy;
        logic [2:0]    lvl;
    } vec_t;

    vec_t tab [12];

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW+KW:0] qa [$];
    logic [DW+KW:0] qb [$];
    int ma = 0;
    int mb = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc_a(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic [KW-1:0] k, input logic rdy);
        logic           in_x, out_x;
        logic [DW+KW:0] w;
        bus_a.fifo_tvalid = v;
        bus_a.fifo_tdata  = d;
        bus_a.fifo_tlast  = l;
        bus_a.fifo_tkeep  = k;
        bus_a.tready      = rdy;
        in_x  = v && bus_a.fifo_tready;
        out_x = bus_a.tvalid && rdy;
        if (out_x) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_spurious: got beat 0x%0h, wanted none", bus_a.tdata);
            end else begin
                w = qa.pop_front();
                chk("a_tdata", 64'(bus_a.tdata), 64'(w[DW-1:0]));
                chk("a_tlast", 64'(bus_a.tlast), 64'(w[DW+KW]));
                chk("a_tkeep", 64'(bus_a.tkeep), 64'(w[DW+KW-1:DW]));
            end
        end
        if (in_x) qa.push_back({l, k, d});
        ma = ma + int'(in_x) - int'(out_x);
        @(posedge clk);
        #1;
        chk("a_level", 64'(level_a), 64'(ma));
        chk("a_fifo_tready", 64'(bus_a.fifo_tready), 64'(ma < DEPTH));
        chk("a_afull", 64'(afull_a), 64'(ma >= 3));
        chk("a_tvalid", 64'(bus_a.tvalid), 64'(ma != 0));
    endtask

    task automatic cyc_b(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic [KW-1:0] k, input logic rdy);
        logic           in_x, out_x;
        logic [DW+KW:0] w;
        bus_b.fifo_tvalid = v;
        bus_b.fifo_tdata  = d;
        bus_b.fifo_tlast  = l;
        bus_b.fifo_tkeep  = k;
        bus_b.tready      = rdy;
        in_x  = v && bus_b.fifo_tready;
        out_x = bus_b.tvalid && rdy;
        if (out_x) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_spurious: got beat 0x%0h, wanted none", bus_b.tdata);
            end else begin
                w = qb.pop_front();
                chk("b_tdata", 64'(bus_b.tdata), 64'(w[DW-1:0]));
                chk("b_tlast", 64'(bus_b.tlast), 64'(w[DW+KW]));
                chk("b_tkeep", 64'(bus_b.tkeep), 64'(w[DW+KW-1:DW]));
            end
        end
        if (in_x) qb.push_back({l, k, d});
        mb = mb + int'(in_x) - int'(out_x);
        @(posedge clk);
        #1;
        chk("b_level", 64'(level_b), 64'(mb));
        chk("b_fifo_tready", 64'(bus_b.fifo_tready), 64'(mb < DEPTH));
        chk("b_afull", 64'(afull_b), 64'(mb >= 3));
    endtask

    initial begin
        int  sent;
        logic rose;
        logic will_in;

        tab[0]  = '{1'b1, 32'h11, 1'b0, 4'hF, 1'b1, 3'd1};
        tab[1]  = '{1'b1, 32'h22, 1'b0, 4'hF, 1'b1, 3'd1};
        tab[2]  = '{1'b1, 32'h33, 1'b1, 4'h3, 1'b1, 3'd1};
        tab[3]  = '{1'b0, 32'h00, 1'b0, 4'h0, 1'b1, 3'd0};
        tab[4]  = '{1'b1, 32'hA0, 1'b0, 4'hF, 1'b0, 3'd1};
        tab[5]  = '{1'b1, 32'hA1, 1'b0, 4'hF, 1'b0, 3'd2};
        tab[6]  = '{1'b1, 32'hA2, 1'b0, 4'hF, 1'b0, 3'd3};
        tab[7]  = '{1'b1, 32'hA3, 1'b1, 4'h1, 1'b0, 3'd4};
        tab[8]  = '{1'b1, 32'hA4, 1'b0, 4'hF, 1'b0, 3'd4};
        tab[9]  = '{1'b0, 32'h00, 1'b0, 4'h0, 1'b1, 3'd3};
        tab[10] = '{1'b0, 32'h00, 1'b0, 4'h0, 1'b1, 3'd2};
        tab[11] = '{1'b1, 32'hB0, 1'b1, 4'h7, 1'b1, 3'd2};

        reset = 1'b1;
        bus_a.fifo_tvalid = 1'b0; bus_a.fifo_tlast = 1'b0; bus_a.fifo_tkeep = '0;
        bus_a.fifo_tdata  = '0;   bus_a.tready     = 1'b0;
        bus_b.fifo_tvalid = 1'b0; bus_b.fifo_tlast = 1'b0; bus_b.fifo_tkeep = '0;
        bus_b.fifo_tdata  = '0;   bus_b.tready     = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_fifo_tready", 64'(bus_a.fifo_tready), 64'd0);
            chk("rst_tvalid", 64'(bus_a.tvalid), 64'd0);
            chk("rst_level", 64'(level_a), 64'd0);
            chk("rst_tstrb", 64'(bus_a.tstrb), 64'hF);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_fifo_tready", 64'(bus_a.fifo_tready), 64'd1);
        chk("rel_tvalid", 64'(bus_a.tvalid), 64'd0);
        chk("rel_level", 64'(level_a), 64'd0);
        chk("rel_b_fifo_tready", 64'(bus_b.fifo_tready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            cyc_a(tab[i].v, tab[i].d, tab[i].l, tab[i].k, tab[i].rdy);
            chk("vec_level", 64'(level_a), 64'(tab[i].lvl));
            if (i >= 4 && i <= 8) chk("stall_tdata", 64'(bus_a.tdata), 64'hA0);
        end

        for (int i = 0; i < 10; i++) begin
            cyc_a(1'b1, 32'hC0 + 32'(i), (i == 9), 4'hF, 1'b1);
            chk("wrap_level", 64'(level_a), 64'd2);
        end
        for (int i = 0; i < 4; i++) cyc_a(1'b0, '0, 1'b0, '0, 1'b1);
        chk("drain_empty", 64'(qa.size()), 64'd0);

        cyc_a(1'b1, 32'hD0, 1'b0, 4'hF, 1'b0);
        cyc_a(1'b1, 32'hD1, 1'b0, 4'hF, 1'b0);
        cyc_a(1'b1, 32'hD2, 1'b0, 4'hF, 1'b0);
        reset = 1'b1;
        bus_a.fifo_tvalid = 1'b0;
        bus_a.tready      = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_tvalid", 64'(bus_a.tvalid), 64'd0);
        chk("mrst_level", 64'(level_a), 64'd0);
        chk("mrst_tdata", 64'(bus_a.tdata), 64'd0);
        chk("mrst_fifo_tready", 64'(bus_a.fifo_tready), 64'd0);
        chk("mrst_afull", 64'(afull_a), 64'd0);
        reset = 1'b0;
        qa.delete();
        ma = 0;
        qb.delete();
        mb = 0;
        @(posedge clk);
        #1;
        chk("mrst_release_tready", 64'(bus_a.fifo_tready), 64'd1);
        cyc_a(1'b1, 32'h55, 1'b1, 4'hF, 1'b1);
        chk("rst_first_word", 64'(bus_a.tdata), 64'h55);
        cyc_a(1'b0, '0, 1'b0, '0, 1'b1);

        cyc_b(1'b1, 32'h100, 1'b0, 4'hF, 1'b1);
        chk("sf3_hold", 64'(bus_b.tvalid), 64'd0);
        cyc_b(1'b1, 32'h101, 1'b0, 4'hF, 1'b1);
        chk("sf3_hold", 64'(bus_b.tvalid), 64'd0);
        cyc_b(1'b1, 32'h102, 1'b1, 4'h3, 1'b1);
        chk("sf3_rise", 64'(bus_b.tvalid), 64'd1);
        chk("sf3_head", 64'(bus_b.tdata), 64'h100);
        for (int i = 0; i < 3; i++) begin
            cyc_b(1'b0, '0, 1'b0, '0, 1'b1);
            chk("sf3_stream", 64'(bus_b.tvalid), 64'(i < 2));
        end

        sent = 0;
        rose = 1'b0;
        for (int c = 0; c < 20; c++) begin
            will_in = (sent < 6) && bus_b.fifo_tready;
            cyc_b((sent < 6), 32'h200 + 32'(sent), (sent == 5), 4'hF, 1'b1);
            if (will_in) sent++;
            if (!rose && bus_b.tvalid) begin
                rose = 1'b1;
                chk("sf6_rise_level", 64'(level_b), 64'd4);
                chk("sf6_head", 64'(bus_b.tdata), 64'h200);
            end
        end
        chk("sf6_rose", 64'(rose), 64'd1);
        chk("sf6_sent", 64'(sent), 64'd6);
        chk("sf6_drained", 64'(qb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
